// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM/owner types and default parameters for the memory arbiter
package mem_arb_pkg;
    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_STARVE_LIMIT = 4;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: data-first winner selection with a bounded fetch starvation guard
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_valid,
    input  logic d_valid,
    input  logic window,
    output logic grant_if,
    output logic grant_d
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;
    logic          starved;
    // fetch wins when alone or once data has been granted STARVE_LIMIT times in a row
    always_comb begin
        starved  = starve_cnt == CW'(STARVE_LIMIT);
        grant_if = window && if_valid && (!d_valid || starved);
        grant_d  = window && d_valid && !grant_if;
    end
    // count data grants that overtake a waiting fetch; saturate at the limit
    always_ff @(posedge clk) begin
        if (!rst_n || !if_valid || grant_if)
            starve_cnt <= '0;
        else if (grant_d && !starved)
            starve_cnt <= starve_cnt + 1'b1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read memory between fetch and load/store ports
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic                d_we,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_resp_valid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int BE_W = DATA_W / 8;
    state_t            state, state_nx;
    owner_t            owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              window, grant_if, grant_d, accept, resp;

    assign window = rst_n && (state == IDLE || state == RESP);
    assign accept = grant_if || grant_d;

    mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_valid (if_req_valid),
        .d_valid  (d_req_valid),
        .window   (window),
        .grant_if (grant_if),
        .grant_d  (grant_d)
    );

    // state register
    always_ff @(posedge clk) begin
        state <= rst_n ? state_nx : IDLE;
    end

    // next state plus handshake, response and memory-strobe outputs; reset masks everything
    always_comb begin
        state_nx      = (state == ISSUE) ? RESP : (accept ? ISSUE : IDLE);
        resp          = rst_n && state == RESP;
        if_req_ready  = grant_if;
        d_req_ready   = grant_d;
        if_resp_valid = resp && owner_q == OWN_IF;
        d_resp_valid  = resp && owner_q == OWN_D;
        if_rdata      = if_resp_valid ? mem_rdata : '0;
        d_rdata       = (d_resp_valid && !we_q) ? mem_rdata : '0;
        mem_we        = rst_n && state == ISSUE && we_q;
    end

    // capture the winning request; fetches are forced to full-word reads
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q <= OWN_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            owner_q <= grant_d ? OWN_D : OWN_IF;
            addr_q  <= grant_d ? d_addr : if_addr;
            we_q    <= grant_d && d_we;
            wdata_q <= grant_d ? d_wdata : '0;
            be_q    <= grant_d ? d_be : '1;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a timeline model
module tb_mem_arbiter;
    localparam int LIM = 4;
    logic        clk = 0, rst_n = 0;
    logic        if_req_valid = 0, if_req_ready, if_resp_valid;
    logic [31:0] if_addr = 0, if_rdata;
    logic        d_req_valid = 0, d_req_ready, d_we = 0, d_resp_valid;
    logic [31:0] d_addr = 0, d_wdata = 0, d_rdata;
    logic [3:0]  d_be = 0, mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    int          errors = 0, checks = 0, cyc = 0;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr), .d_we(d_we),
        .d_wdata(d_wdata), .d_be(d_be), .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, got, exp, cyc);
        end
    endtask

    // the shared memory the arbiter drives, with a preload port used during reset
    logic [31:0] env_mem [256];
    logic        load_en = 0;
    logic [7:0]  load_idx = 0;
    logic [31:0] load_data = 0;
    always @(posedge clk) begin
        if (load_en) env_mem[load_idx] <= load_data;
        else if (mem_we)
            for (int b = 0; b < 4; b++) if (mem_be[b]) env_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= env_mem[mem_addr[9:2]];
    end

    // reference model: a transaction accepted at cycle A drives memory at A+1, responds at A+2
    logic [31:0] ref_mem [256];
    int          last_acc = -100, starve = 0;
    bit          last_d = 0, last_we = 0;
    logic [31:0] last_addr = 0, last_wdata = 0;
    logic [3:0]  last_be = 0;
    bit          grant_q[$];
    int          acc_q[$], if_rc[$], d_rc[$];
    logic [31:0] if_rd[$], d_rd[$];
    bit          if_hs = 0, d_hs = 0;
    bit          p_rst = 0, p_ifv = 0, p_ifr = 0, p_dv = 0, p_dr = 0, p_dwe = 0;
    logic [31:0] p_ifa = 0, p_da = 0, p_dwd = 0;
    logic [3:0]  p_dbe = 0;

    // per-cycle compare of every DUT output against the model, then advance the model
    always @(negedge clk) begin
        bit win, e_if, e_d, due, iss;
        logic [31:0] e_data;
        if (load_en) ref_mem[load_idx] = load_data;
        win  = rst_n && (cyc - last_acc >= 2);
        e_if = win && if_req_valid && (!d_req_valid || starve == LIM);
        e_d  = win && d_req_valid && !e_if;
        chk("if_req_ready", 32'(if_req_ready), 32'(e_if));
        chk("d_req_ready", 32'(d_req_ready), 32'(e_d));
        due    = rst_n && (cyc == last_acc + 2);
        e_data = (due && !last_we) ? ref_mem[last_addr[9:2]] : 32'h0;
        chk("if_resp_valid", 32'(if_resp_valid), 32'(due && !last_d));
        chk("d_resp_valid", 32'(d_resp_valid), 32'(due && last_d));
        chk("if_rdata", if_rdata, (due && !last_d) ? e_data : 32'h0);
        chk("d_rdata", d_rdata, (due && last_d) ? e_data : 32'h0);
        iss = rst_n && (cyc == last_acc + 1);
        chk("mem_we", 32'(mem_we), 32'(iss && last_we));
        if (iss) begin
            chk("mem_addr", mem_addr, last_addr);
            chk("mem_be", 32'(mem_be), 32'(last_be));
            if (last_we) chk("mem_wdata", mem_wdata, last_wdata);
        end
        if (iss && last_we)
            for (int b = 0; b < 4; b++) if (last_be[b]) ref_mem[last_addr[9:2]][8*b +: 8] = last_wdata[8*b +: 8];
        if (if_resp_valid) begin if_rc.push_back(cyc); if_rd.push_back(if_rdata); end
        if (d_resp_valid) begin d_rc.push_back(cyc); d_rd.push_back(d_rdata); end
        if (if_req_ready) if_hs = 1;
        if (d_req_ready) d_hs = 1;
        if (p_rst && rst_n && p_ifv && !p_ifr)
            assert (if_req_valid && if_addr == p_ifa) else $error("fetch requester changed before ready");
        if (p_rst && rst_n && p_dv && !p_dr)
            assert (d_req_valid && d_addr == p_da && d_we == p_dwe && d_wdata == p_dwd && d_be == p_dbe)
                else $error("data requester changed before ready");
        if (!rst_n) begin
            last_acc = -100;
            starve   = 0;
        end else begin
            if (!if_req_valid || e_if) starve = 0;
            else if (e_d && starve < LIM) starve++;
            if (e_if || e_d) begin
                last_acc   = cyc;
                last_d     = e_d;
                last_we    = e_d && d_we;
                last_addr  = e_d ? d_addr : if_addr;
                last_wdata = d_wdata;
                last_be    = e_d ? d_be : 4'hF;
                grant_q.push_back(e_d);
                acc_q.push_back(cyc);
            end
        end
        p_rst = rst_n; p_ifv = if_req_valid; p_ifr = if_req_ready; p_ifa = if_addr;
        p_dv = d_req_valid; p_dr = d_req_ready; p_da = d_addr; p_dwe = d_we; p_dwd = d_wdata; p_dbe = d_be;
    end

    function automatic logic [31:0] qd(input logic [31:0] q[$], input int i);
        return i < q.size() ? q[i] : 32'hxxxxxxxx;
    endfunction
    function automatic logic [31:0] qi(input int q[$], input int i);
        return i < q.size() ? 32'(q[i]) : 32'hxxxxxxxx;
    endfunction
    function automatic logic [31:0] raddr();
        return 32'($urandom_range(0, 255)) << 2;
    endfunction

    task automatic clear_logs();
        grant_q.delete(); acc_q.delete(); if_rc.delete(); if_rd.delete(); d_rc.delete(); d_rd.delete();
    endtask

    // present one request, hold it until ready, then withdraw it in the following cycle
    task automatic req(input bit d, input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        bit got = 0;
        @(posedge clk); #1;
        if (d) begin d_req_valid = 1; d_addr = a; d_we = we; d_wdata = wd; d_be = be; end
        else begin if_req_valid = 1; if_addr = a; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = d ? d_req_ready : if_req_ready;
        end
        if (!got) chk("req_timeout", 32'(got), 32'h1);
        @(posedge clk); #1;
        if (d) d_req_valid = 0; else if_req_valid = 0;
    endtask

    initial begin
        load_en = 1;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            load_idx  = 8'(i);
            load_data = (i == 0) ? 32'h11111111 : (i == 1) ? 32'h22222222 : (i == 2) ? 32'h33333333 :
                        (i == 4) ? 32'h00500093 : (i == 16) ? 32'h0 : (i == 32) ? 32'hCAFEF00D :
                        {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'hC3};
        end
        @(posedge clk); #1;
        load_en = 0;
        @(negedge clk);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_readies", 32'({if_req_ready, d_req_ready}), 32'h0);
        @(posedge clk); #1;
        rst_n = 1;

        clear_logs();
        req(0, 0, 32'h10, 0, 0);
        repeat (4) @(posedge clk);
        chk("fetch_n_resp", 32'(if_rd.size()), 32'h1);
        chk("fetch_data", qd(if_rd, 0), 32'h00500093);
        chk("fetch_latency", qi(if_rc, 0) - qi(acc_q, 0), 32'h2);
        chk("fetch_no_d_resp", 32'(d_rd.size()), 32'h0);

        clear_logs();
        req(1, 1, 32'h40, 32'hDEADBEEF, 4'hF);
        req(1, 0, 32'h40, 32'h0, 4'hF);
        req(1, 1, 32'h40, 32'h000000AA, 4'h1);
        req(1, 0, 32'h40, 32'h0, 4'hF);
        repeat (4) @(posedge clk);
        chk("st_ld_n_resp", 32'(d_rd.size()), 32'h4);
        chk("store_ack_data", qd(d_rd, 0), 32'h0);
        chk("load_after_store", qd(d_rd, 1), 32'hDEADBEEF);
        chk("be_store_ack", qd(d_rd, 2), 32'h0);
        chk("load_after_be_store", qd(d_rd, 3), 32'hDEADBEAA);

        clear_logs();
        @(posedge clk); #1;
        if_req_valid = 1; if_addr = 32'h4;
        d_req_valid = 1; d_addr = 32'h0; d_we = 0; d_wdata = 0; d_be = 4'hF;
        repeat (20) @(posedge clk);
        #1;
        if_hs = 0; d_hs = 0;
        for (int i = 0; i < 12 && (if_req_valid || d_req_valid); i++) begin
            @(posedge clk); #1;
            if (d_hs) d_req_valid = 0;
            if (if_hs) if_req_valid = 0;
        end
        repeat (4) @(posedge clk);
        chk("contention_order", {22'h0, grant_q[0], grant_q[1], grant_q[2], grant_q[3], grant_q[4],
            grant_q[5], grant_q[6], grant_q[7], grant_q[8], grant_q[9]}, 32'b1111011110);
        chk("contention_rate", qi(acc_q, 9) - qi(acc_q, 0), 32'd18);

        clear_logs();
        req(0, 0, 32'h0, 0, 0);
        req(0, 0, 32'h4, 0, 0);
        req(0, 0, 32'h8, 0, 0);
        repeat (4) @(posedge clk);
        chk("b2b_acc_gap1", qi(acc_q, 1) - qi(acc_q, 0), 32'h2);
        chk("b2b_acc_gap2", qi(acc_q, 2) - qi(acc_q, 1), 32'h2);
        chk("b2b_resp_lat", qi(if_rc, 2) - qi(acc_q, 2), 32'h2);
        chk("b2b_word0", qd(if_rd, 0), 32'h11111111);
        chk("b2b_word1", qd(if_rd, 1), 32'h22222222);
        chk("b2b_word2", qd(if_rd, 2), 32'h33333333);

        clear_logs();
        req(1, 1, 32'h80, 32'h12345678, 4'hF);
        rst_n = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_mem_we", 32'(mem_we), 32'h0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_mem_wdata", mem_wdata, 32'h0);
        chk("midrst_resp", 32'({if_resp_valid, d_resp_valid}), 32'h0);
        @(posedge clk); #1;
        rst_n = 1;
        repeat (3) @(posedge clk);
        chk("midrst_no_resp", 32'(d_rd.size()), 32'h0);
        chk("midrst_mem_kept", env_mem[32], 32'hCAFEF00D);
        req(1, 0, 32'h80, 32'h0, 4'hF);
        repeat (4) @(posedge clk);
        chk("midrst_reload", qd(d_rd, 0), 32'hCAFEF00D);

        if_hs = 0; d_hs = 0;
        repeat (3000) begin
            @(posedge clk); #1;
            if (if_hs || !if_req_valid) begin
                if_hs = 0;
                if_req_valid = $urandom_range(0, 2) != 0;
                if_addr = raddr();
            end
            if (d_hs || !d_req_valid) begin
                d_hs = 0;
                d_req_valid = $urandom_range(0, 2) != 0;
                d_we = 1'($urandom_range(0, 1));
                d_addr = raddr();
                d_wdata = $urandom;
                d_be = 4'($urandom);
            end
        end
        @(posedge clk); #1;
        if_req_valid = 0; d_req_valid = 0;
        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-ported, synchronous-read memory between the CPU's instruction-fetch port and its load/store port. It lets the core run from a unified memory image instead of separate instruction and data memories, and sits between the CPU datapath and the shared memory instance. Each port uses a valid/ready request handshake and a response pulse. Data requests have priority, and a bounded starvation guard ensures fetch is eventually served.

## Interface
- ADDR_W, 32, address width of both ports and the memory
- DATA_W, 32, data width; must be a multiple of 8
- STARVE_LIMIT, 4, maximum consecutive data grants while fetch waits; must be ≥1
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- if_req_valid  in  1  fetch request present
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  ADDR_W  fetch byte address
- if_resp_valid  out  1  one-cycle pulse, fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- d_req_valid  in  1  data request present
- d_req_ready  out  1  data request accepted this cycle
- d_addr  in  ADDR_W  data byte address
- d_we  in  1  1 = store, 0 = load
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_resp_valid  out  1  one-cycle pulse, load data or store acknowledge
- d_rdata  out  DATA_W  load data; 0 for a store acknowledge
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data, valid the cycle after address presentation

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - ISSUE: the captured request drives the memory.
  - RESP: the response is delivered.
- FSM transitions:
  - IDLE→ISSUE on accept.
  - ISSUE→RESP unconditionally.
  - RESP→ISSUE on accept.
  - RESP→IDLE otherwise.
- Accept windows: IDLE and RESP only. Both ready outputs are 0 in ISSUE.
- At most one ready output is high per cycle. Ready is asserted only to the winner, and is combinational from state, valids and the starvation count.
- Winner selection:
  - Only one valid: that port wins.
  - Both valid: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- Starvation counter (starve_cnt):
  - Increments on a data grant made while if_req_valid is 1.
  - Clears on a fetch grant.
  - Clears in any cycle where if_req_valid is 0.
  - Saturates at STARVE_LIMIT.
- On accept, the following are captured into request registers:
  - owner
  - addr
  - we (forced 0 for fetch)
  - wdata
  - be (forced all-ones for fetch)
- ISSUE drives mem_addr, mem_we, mem_wdata and mem_be from the captured registers. The memory write commits at the end of ISSUE.
- RESP pulses the owner's resp_valid. Read data is passed through: rdata = mem_rdata for loads and fetches, 0 for stores. The non-owner's resp_valid stays 0.
- Outside ISSUE, mem_we = 0. mem_addr, mem_wdata and mem_be hold their last captured values.
- Requester rules (checked by bench assertions):
  - Once valid is asserted, valid and all request fields stay stable until ready.
  - Responses have no back-pressure; requesters always consume them.

## Timing
- Accept at cycle T; memory is driven at T+1; resp_valid=1 at T+2.
- Load-use latency: 2 cycles.
- Back-to-back throughput: one transaction per 2 cycles, since a new accept is allowed in the RESP cycle.
- Reset state, effective at the first clock edge with rst_n=0:
  - state = IDLE, starve_cnt = 0
  - all capture registers = 0
  - mem_we = 0, mem_addr = 0
  - both resp_valid = 0, both rdata = 0
  - both ready = 0 while rst_n is low
- Reset mid-operation: any in-flight transaction is dropped with no response. A store captured but not yet in ISSUE never writes.
- Simultaneous events: in RESP, a response to one port and an accept of either port (including the same port) occur in the same cycle.

## Structure
- Package mem_arb_pkg holds:
  - state enum: IDLE, ISSUE, RESP
  - owner enum: OWN_IF, OWN_D
  - default parameter constants
- Sub-module mem_arb_prio: winner selection plus starvation counter.
  - Inputs: clk, rst_n, both valids, accept window.
  - Outputs: grant_if, grant_d.
- The top level holds the FSM, capture registers and response muxing.

## Test plan
- Single fetch: if_addr=0x10 with mem[0x10]=0x00500093 → if_req_ready at T, if_resp_valid at T+2 with if_rdata=0x00500093, d_resp_valid stays 0.
- Store then load: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_be=0xF, then a load from 0x40 → store ack with d_rdata=0, then load d_rdata=0xDEADBEEF.
- Byte-enable store: 0x40 holds 0xDEADBEEF; store d_wdata=0x000000AA with d_be=0x1 → subsequent load returns 0xDEADBEAA.
- Contention with STARVE_LIMIT=4, both valids held high → grant order D,D,D,D,IF,D,D,D,D,IF; a ready pulse every 2 cycles, never both readies high together.
- Back-to-back fetches at 0x0, 0x4, 0x8 → accepts at T, T+2, T+4; responses at T+2, T+4, T+6 with the correct words.
- Reset mid-operation: rst_n=0 during ISSUE of a store to 0x80 → no d_resp_valid, mem[0x80] unchanged, all outputs at reset values on the next cycle.
